ins_fetch: RTL

- Instruction-side responder to the program counter. It accepts the 4-bit PC_CURR address and returns the registered 16-bit INS word that the PC, ALU and decode logic consume.
- It holds a 16 x 16-bit instruction store. The store is loaded serially, one nibble per cycle, from an external programmer port.
- It drives cpu_hold so the CPU keeps the PC at 0 until a complete program is present.

---
 rtl/ins_fetch.sv | 121 ++++++++++++
 1 files changed

// File: rtl/ins_fetch.sv
// Instruction store for the PC: serial nibble loader plus a registered fetch port.
// Fetch latency 1 clock (INS straight from a flop); load accepts one nibble per load_en cycle.
// No backpressure: the loader may gap load_en freely; cpu_hold stalls the CPU until a full program is present.
module ins_fetch #(
  parameter int AW = 4,
  parameter int DW = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          load_start,
  input  logic          load_en,
  input  logic [3:0]    load_nib,
  input  logic [AW-1:0] PC_CURR,
  output logic [DW-1:0] INS,
  output logic          ins_valid,
  output logic          cpu_hold,
  output logic          load_done
);

  localparam int NPW   = DW / 4;                      // nibbles per word
  localparam int CW    = (NPW > 1) ? $clog2(NPW) : 1; // nibble counter width
  localparam int DEPTH = 1 << AW;

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_RUN
  } state_t;

  state_t        r_state;
  logic [AW-1:0] r_wptr;
  logic [CW-1:0] r_cnt;
  logic [DW-1:0] r_shift;
  logic [DW-1:0] r_mem [DEPTH];

  logic [DW-1:0] w_word;
  logic          w_nib;
  logic          w_word_done;
  logic          w_last;

  // Incoming nibble lands in the low end; MS nibble of a word arrives first
  assign w_word      = DW'({r_shift, load_nib});
  // load_start wins over load_en, so a restart cycle never consumes a nibble
  assign w_nib       = (r_state == S_LOAD) && load_en && !load_start;
  assign w_word_done = w_nib && (r_cnt == CW'(NPW - 1));
  assign w_last      = w_word_done && (r_wptr == AW'(DEPTH - 1));

  // Store write: the completed word (including this cycle's nibble) goes in on the same edge
  always_ff @(posedge clk) begin
    if (w_word_done) begin
      r_mem[r_wptr] <= w_word;
    end
  end

  // Control FSM with registered outputs; INS is forced to 0 whenever the CPU is held
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_wptr    <= '0;
      r_cnt     <= '0;
      r_shift   <= '0;
      INS       <= '0;
      ins_valid <= 1'b0;
      cpu_hold  <= 1'b1;
      load_done <= 1'b0;
    end else begin
      load_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (load_start) begin
            r_state <= S_LOAD;
            r_wptr  <= '0;
            r_cnt   <= '0;
            r_shift <= '0;
          end
        end

        S_LOAD: begin
          if (load_start) begin
            r_wptr  <= '0;
            r_cnt   <= '0;
            r_shift <= '0;
          end else if (load_en) begin
            r_shift <= w_word;
            if (w_word_done) begin
              r_cnt  <= '0;
              r_wptr <= r_wptr + AW'(1);  // wraps to 0 after the last word
              if (w_last) begin
                r_state   <= S_RUN;
                cpu_hold  <= 1'b0;
                load_done <= 1'b1;
              end
            end else begin
              r_cnt <= r_cnt + CW'(1);
            end
          end
        end

        S_RUN: begin
          if (load_start) begin
            r_state   <= S_LOAD;
            r_wptr    <= '0;
            r_cnt     <= '0;
            r_shift   <= '0;
            INS       <= '0;
            ins_valid <= 1'b0;
            cpu_hold  <= 1'b1;
          end else begin
            INS       <= r_mem[PC_CURR];
            ins_valid <= 1'b1;
          end
        end

        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule
